fc1004_zbank_arbiter: RTL

//  Sequences Z80 accesses to the 0x8000-0xFFFF bank window onto the 68k bus (VA/VD) inside fc1004.

---
 rtl/fc1004_zbank_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fc1004_zbank_arbiter.sv
// Z80 bank-window bridge onto the 68k bus: holds the 9-bit bank register and
// runs one bus request/grant plus one AS/UDS/LDS/DTACK cycle per Z80 access.
module fc1004_zbank_arbiter #(
  parameter int unsigned SETUP   = 1,
  parameter int unsigned TIMEOUT = 128
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        z_req,
  input  logic        z_wr,
  input  logic [14:0] z_a,
  input  logic [7:0]  z_do,
  output logic [7:0]  z_di,
  output logic        z_wait,
  input  logic        bank_we,
  input  logic        bank_d,
  input  logic        bg,
  input  logic        bgack_i,
  output logic        br,
  output logic        bgack_o,
  output logic        bus_oe,
  output logic [22:0] va,
  output logic        as,
  output logic        uds,
  output logic        lds,
  output logic        rw,
  input  logic        dtack,
  input  logic [15:0] vd_i,
  output logic [15:0] vd_o,
  output logic        vd_oe
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, REQ, OWN, STRB, DTW, DONE, HOLD} state_t;

  state_t          state;
  logic [8:0]      bank;
  logic [23:0]     addr;
  logic            wr;
  logic [7:0]      wdata;
  logic [2:0]      scnt;
  logic [TW-1:0]   tcnt;

  // Serial bank load: new bit enters at the top, nine writes fill it.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET)        bank <= '0;
    else if (bank_we) bank <= {bank_d, bank[8:1]};
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      addr    <= '0;
      wr      <= 1'b0;
      wdata   <= '0;
      scnt    <= '0;
      tcnt    <= '0;
      z_di    <= 8'hFF;
      br      <= 1'b0;
      bgack_o <= 1'b0;
      bus_oe  <= 1'b0;
      as      <= 1'b0;
      uds     <= 1'b0;
      lds     <= 1'b0;
      rw      <= 1'b1;
      vd_oe   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (z_req) begin
          state <= REQ;
          addr  <= {bank, z_a};
          wr    <= z_wr;
          wdata <= z_do;
          br    <= 1'b1;
        end
        // Take the bus only when nobody else owns it and the previous cycle is over.
        REQ: if (bg && !bgack_i && !dtack) begin
          state   <= OWN;
          br      <= 1'b0;
          bgack_o <= 1'b1;
          bus_oe  <= 1'b1;
          rw      <= ~wr;
          scnt    <= '0;
        end
        OWN: begin
          if (scnt == 3'(SETUP - 1)) begin
            state <= STRB;
            as    <= 1'b1;
            uds   <= ~addr[0];
            lds   <= addr[0];
            vd_oe <= wr;
          end else begin
            scnt <= scnt + 3'd1;
          end
        end
        STRB: begin
          state <= DTW;
          tcnt  <= '0;
        end
        // dtack is checked first so a late acknowledge still returns real data.
        DTW: begin
          if (dtack || tcnt == TW'(TIMEOUT - 1)) begin
            state <= DONE;
            as    <= 1'b0;
            uds   <= 1'b0;
            lds   <= 1'b0;
            vd_oe <= 1'b0;
            if (!dtack)  z_di <= 8'hFF;
            else if (!wr) z_di <= addr[0] ? vd_i[7:0] : vd_i[15:8];
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DONE: begin
          state   <= HOLD;
          bgack_o <= 1'b0;
          bus_oe  <= 1'b0;
          rw      <= 1'b1;
        end
        HOLD: if (!z_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign va     = addr[23:1];
  assign vd_o   = {wdata, wdata};
  assign z_wait = z_req && (state != DONE) && (state != HOLD);

endmodule
